// File: rtl/spi_master16_pkg.sv
`default_nettype none
// ============================================================================
// Module  : spi_master16_pkg
// Brief   : Shared word width, bit-counter width and FSM state encoding.
// Revision: 1.0 - initial release
// ============================================================================
package spi_master16_pkg;

  localparam int SPI_WORD_W = 16;
  localparam int BITCNT_W   = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_LAST  = 3'd4,
    ST_GAP   = 3'd5
  } spi_state_e;

endpackage
`default_nettype wire

// File: rtl/spi_clk_div.sv
`default_nettype none
// ============================================================================
// Module  : spi_clk_div
// Brief   : Half-period tick generator; counts 0..CLK_DIV-1, restartable.
// Revision: 1.0 - initial release
// ============================================================================
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Tick must not depend on restart_i: restart is derived from the FSM's
  // next state, which itself depends on the tick.
  assign tick_o = (cnt_q == CNT_TERM);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (restart_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    assert (CLK_DIV >= 2);
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_master16.sv
`default_nettype none
// ============================================================================
// Module  : spi_master16
// Brief   : SPI mode-0 master, 16-bit MSB-first words, multi-word frames.
// Revision: 1.0 - initial release
// ============================================================================
module spi_master16
  import spi_master16_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SPI_WORD_W-1:0] tx_data,
  input  logic                  tx_last,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [SPI_WORD_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  SCK,
  output logic                  MOSI,
  input  logic                  MISO,
  output logic                  SSEL
);

  localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [GAP_W-1:0]    GAP_TERM  = GAP_W'(CS_GAP - 1);
  localparam logic [BITCNT_W-1:0] WORD_BITS = BITCNT_W'(SPI_WORD_W);

  spi_state_e            state_q, state_d;
  logic                  tick, restart, ready, accept;
  logic                  wait_q, wait_d;
  logic                  last_q, last_d;
  logic [BITCNT_W-1:0]   bitcnt_q, bitcnt_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [SPI_WORD_W-1:0] tx_sh_q, tx_sh_d;
  logic [SPI_WORD_W-1:0] rx_sh_q, rx_sh_d;
  logic [SPI_WORD_W-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  sck_q, sck_d;
  logic                  ssel_q, ssel_d;
  logic [1:0]            miso_sync_q;

  assign restart = (state_d != state_q);

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk       (clk),
    .reset     (reset),
    .restart_i (restart),
    .tick_o    (tick)
  );

  // A continuing frame offers tx_ready from the final LAST cycle onwards,
  // and keeps offering it while stalled there.
  assign ready  = !reset && ((state_q == ST_IDLE) ||
                  ((state_q == ST_LAST) && !last_q && (tick || wait_q)));
  assign accept = tx_valid && ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_SETUP;
      ST_SETUP: if (tick) state_d = ST_HIGH;
      ST_HIGH:  if (tick) state_d = ST_LOW;
      ST_LOW:   if (tick) state_d = (bitcnt_q < WORD_BITS) ? ST_HIGH : ST_LAST;
      ST_LAST: begin
        if (last_q) begin
          if (tick) state_d = ST_GAP;
        end else if (accept) begin
          state_d = ST_HIGH;
        end
      end
      ST_GAP:   if (tick && (gap_q == GAP_TERM)) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_sh_d    = tx_sh_q;
    last_d     = last_q;
    bitcnt_d   = bitcnt_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    gap_d      = gap_q;
    wait_d     = (state_q == ST_LAST) && (state_d == ST_LAST) && (tick || wait_q);
    sck_d      = (state_d == ST_HIGH);
    ssel_d     = (state_d == ST_IDLE) || (state_d == ST_GAP);

    if (accept) begin
      tx_sh_d  = tx_data;
      last_d   = tx_last;
      bitcnt_d = '0;
    end
    // Rising edge: capture MISO; a new word from LAST restarts the bit count.
    if (restart && (state_d == ST_HIGH)) begin
      bitcnt_d = ((state_q == ST_LAST) ? '0 : bitcnt_q) + BITCNT_W'(1);
      rx_sh_d  = {rx_sh_q[SPI_WORD_W-2:0], miso_sync_q[1]};
    end
    if (restart && (state_d == ST_LOW)) begin
      tx_sh_d = {tx_sh_q[SPI_WORD_W-2:0], 1'b0};
    end
    if (restart && (state_d == ST_LAST)) begin
      rx_data_d  = rx_sh_q;
      rx_valid_d = 1'b1;
    end
    if (restart && (state_d == ST_GAP)) begin
      gap_d = '0;
    end else if ((state_q == ST_GAP) && tick) begin
      gap_d = gap_q + GAP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wait_q      <= 1'b0;
      last_q      <= 1'b0;
      bitcnt_q    <= '0;
      gap_q       <= '0;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      sck_q       <= 1'b0;
      ssel_q      <= 1'b1;
      miso_sync_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      last_q      <= last_d;
      bitcnt_q    <= bitcnt_d;
      gap_q       <= gap_d;
      tx_sh_q     <= tx_sh_d;
      rx_sh_q     <= rx_sh_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      sck_q       <= sck_d;
      ssel_q      <= ssel_d;
      miso_sync_q <= {miso_sync_q[0], MISO};
    end
  end

  assign tx_ready = ready;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = (state_q != ST_IDLE);
  assign SCK      = sck_q;
  assign SSEL     = ssel_q;
  assign MOSI     = tx_sh_q[SPI_WORD_W-1];

endmodule
`default_nettype wire
